// File: rtl/mnist_pkg.sv
// Shared defaults and FSM state type for the classifier accuracy monitor.
package mnist_pkg;

   localparam int N_CLASS   = 10;
   localparam int N_SAMPLES = 2047;
   localparam int CNT_W     = $clog2(N_SAMPLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational one-hot decoder: reports the set bit position and whether exactly one bit is set.
module onehot_to_idx
   import mnist_pkg::*;
#(
   parameter int N_CLASS = mnist_pkg::N_CLASS
) (
   input  logic [N_CLASS-1:0] vec,
   output logic [3:0]         idx,
   output logic               is_onehot
);

   // For a non-one-hot input idx is meaningless; callers gate on is_onehot.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_CLASS; i++) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
   end

   assign is_onehot = (vec != '0) && ((vec & (vec - N_CLASS'(1))) == '0);

endmodule

// File: rtl/accuracy_monitor.sv
// Counts accepted, correct and malformed-label samples over one evaluation run,
// plus a per-class hit counter readable through class_sel.
module accuracy_monitor #(
   parameter int N_CLASS   = mnist_pkg::N_CLASS,
   parameter int N_SAMPLES = mnist_pkg::N_SAMPLES,
   parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pred_valid,
   input  logic [N_CLASS-1:0] pred,
   input  logic [N_CLASS-1:0] label,
   input  logic [3:0]         class_sel,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   total_cnt,
   output logic [CNT_W-1:0]   correct_cnt,
   output logic [CNT_W-1:0]   bad_label_cnt,
   output logic [CNT_W-1:0]   class_hit_cnt
);
   import mnist_pkg::*;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] total_reg, correct_reg, bad_reg;
   logic [CNT_W-1:0] class_cnt [N_CLASS];

   logic       accept;
   logic       clear;
   logic       hit;
   logic [3:0] label_idx;
   logic       label_onehot;

   onehot_to_idx #(.N_CLASS(N_CLASS)) u_label_dec (
      .vec       (label),
      .idx       (label_idx),
      .is_onehot (label_onehot)
   );

   // start is only honoured outside RUN; it restarts from IDLE or DONE alike.
   assign accept = (state_reg == RUN) && pred_valid;
   assign clear  = start && (state_reg != RUN);
   assign hit    = accept && label_onehot && (pred == label);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = RUN;
         RUN:  if (accept && (total_reg == CNT_W'(N_SAMPLES - 1))) state_next = DONE;
         DONE: if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         total_reg   <= '0;
         correct_reg <= '0;
         bad_reg     <= '0;
      end else if (accept) begin
         total_reg <= total_reg + CNT_W'(1);
         if (!label_onehot) begin
            bad_reg <= bad_reg + CNT_W'(1);
         end
         if (hit) begin
            correct_reg <= correct_reg + CNT_W'(1);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_class
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (!rst_n || clear) begin
               cnt_reg <= '0;
            end else if (hit && (label_idx == 4'(gi))) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign class_cnt[gi] = cnt_reg;
      end
   endgenerate

   // Out-of-range selects fall through to zero.
   always_comb begin
      class_hit_cnt = '0;
      for (int i = 0; i < N_CLASS; i++) begin
         if (class_sel == 4'(i)) begin
            class_hit_cnt = class_cnt[i];
         end
      end
   end

   assign busy          = (state_reg == RUN);
   assign done          = (state_reg == DONE);
   assign total_cnt     = total_reg;
   assign correct_cnt   = correct_reg;
   assign bad_label_cnt = bad_reg;

endmodule

// File: tb/tb_accuracy_monitor.sv
// Self-checking bench for accuracy_monitor: directed scenarios plus a randomized
// stream compared against a behavioural model of the counting rules.
module tb_accuracy_monitor;

   localparam int N  = 10;
   localparam int NS = 2047;
   localparam int W  = 11;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         pred_valid = 1'b0;
   logic [N-1:0] pred = '0;
   logic [N-1:0] label = '0;
   logic [3:0]   class_sel = '0;
   logic         busy, done;
   logic [W-1:0] total_cnt, correct_cnt, bad_label_cnt, class_hit_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: 0 = idle, 1 = running, 2 = finished.
   int m_st = 0;
   int m_total = 0, m_correct = 0, m_bad = 0;
   int m_class [N];

   always #5 clk = ~clk;

   accuracy_monitor dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .pred_valid    (pred_valid),
      .pred          (pred),
      .label         (label),
      .class_sel     (class_sel),
      .busy          (busy),
      .done          (done),
      .total_cnt     (total_cnt),
      .correct_cnt   (correct_cnt),
      .bad_label_cnt (bad_label_cnt),
      .class_hit_cnt (class_hit_cnt)
   );

   function automatic void model_clear();
      m_total = 0;
      m_correct = 0;
      m_bad = 0;
      for (int i = 0; i < N; i++) m_class[i] = 0;
   endfunction

   function automatic int model_class(input logic [3:0] sel);
      if (sel < 4'(N)) return m_class[sel];
      return 0;
   endfunction

   // Drive one cycle of stimulus, clock it, and advance the model by the same edge.
   task automatic cyc(input logic st, input logic pv, input logic [N-1:0] p, input logic [N-1:0] l);
      start = st;
      pred_valid = pv;
      pred = p;
      label = l;
      @(posedge clk);
      if (!rst_n) begin
         m_st = 0;
         model_clear();
      end else if (st && m_st != 1) begin
         m_st = 1;
         model_clear();
      end else if (m_st == 1 && pv) begin
         m_total++;
         if ($countones(l) != 1) begin
            m_bad++;
         end else if (p == l) begin
            m_correct++;
            for (int i = 0; i < N; i++) if (l[i]) m_class[i]++;
         end
         if (m_total == NS) m_st = 2;
      end
      #1;
      start = 1'b0;
      pred_valid = 1'b0;
   endtask

   function automatic logic [N-1:0] onehot(input int c);
      logic [N-1:0] v;
      v = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(1'b1, 1'b1, onehot(4), onehot(4));
      cyc(1'b0, 1'b0, '0, '0);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cyc(1'b0, 1'b1, onehot(1), onehot(1));
         n_vec++;
         if ({busy, done} !== 2'b00 || total_cnt !== '0 || correct_cnt !== '0 || bad_label_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_idle cyc%0d: busy=%0b done=%0b tot=%0d cor=%0d bad=%0d, want all 0",
                     c, busy, done, total_cnt, correct_cnt, bad_label_cnt);
         end
      end
      for (int s = 0; s < 16; s++) begin
         class_sel = 4'(s);
         #1;
         n_vec++;
         if (class_hit_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_class sel=%0d: got %0d want 0", s, class_hit_cnt);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_all_match();
      cyc(1'b1, 1'b1, onehot(2), onehot(2));
      n_vec++;
      if (busy !== 1'b1 || total_cnt !== '0) begin
         n_err++;
         $display("FAIL start_cycle: busy=%0b tot=%0d want busy=1 tot=0", busy, total_cnt);
      end
      for (int i = 0; i < NS; i++) begin
         cyc(1'b0, 1'b1, 10'b0000000100, 10'b0000000100);
         if (i == NS - 2) begin
            n_vec++;
            if (done !== 1'b0) begin
               n_err++;
               $display("FAIL early_done: got %0b want 0", done);
            end
         end
      end
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || total_cnt !== W'(2047) || correct_cnt !== W'(2047)) begin
         n_err++;
         $display("FAIL all_match_end: done=%0b busy=%0b tot=%0d cor=%0d want 1 0 2047 2047",
                  done, busy, total_cnt, correct_cnt);
      end
      class_sel = 4'd2; #1;
      n_vec++;
      if (class_hit_cnt !== W'(2047)) begin
         n_err++;
         $display("FAIL class2: got %0d want 2047", class_hit_cnt);
      end
      class_sel = 4'd3; #1;
      n_vec++;
      if (class_hit_cnt !== '0) begin
         n_err++;
         $display("FAIL class3: got %0d want 0", class_hit_cnt);
      end
      class_sel = 4'd12; #1;
      n_vec++;
      if (class_hit_cnt !== '0) begin
         n_err++;
         $display("FAIL class12: got %0d want 0", class_hit_cnt);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, onehot(2), onehot(2));
      n_vec++;
      if (done !== 1'b1 || total_cnt !== W'(2047) || correct_cnt !== W'(2047)) begin
         n_err++;
         $display("FAIL done_hold: done=%0b tot=%0d cor=%0d want 1 2047 2047", done, total_cnt, correct_cnt);
      end
      $display("test_all_match done");
   endtask

   task automatic test_alternating();
      cyc(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < NS; i++) begin
         if (i % 2 == 0) cyc(1'b0, 1'b1, onehot((i / 2) % N), onehot((i / 2) % N));
         else            cyc(1'b0, 1'b1, 10'b0000000001, 10'b0000000010);
      end
      n_vec++;
      if (correct_cnt !== W'(1024) || total_cnt !== W'(2047) || done !== 1'b1) begin
         n_err++;
         $display("FAIL alternating: cor=%0d tot=%0d done=%0b want 1024 2047 1", correct_cnt, total_cnt, done);
      end
      for (int s = 0; s < N; s++) begin
         class_sel = 4'(s); #1;
         n_vec++;
         if (class_hit_cnt !== W'(model_class(4'(s)))) begin
            n_err++;
            $display("FAIL alt_class%0d: got %0d want %0d", s, class_hit_cnt, model_class(4'(s)));
         end
      end
      $display("test_alternating done");
   endtask

   task automatic test_bad_label();
      cyc(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 10'b0, 10'b0);
      cyc(1'b0, 1'b1, onehot(7), onehot(7));
      cyc(1'b0, 1'b1, 10'b0000110000, 10'b0000110000);
      n_vec++;
      if (bad_label_cnt !== W'(4) || correct_cnt !== W'(1) || total_cnt !== W'(5)) begin
         n_err++;
         $display("FAIL bad_label: bad=%0d cor=%0d tot=%0d want 4 1 5", bad_label_cnt, correct_cnt, total_cnt);
      end
      class_sel = 4'd4; #1;
      n_vec++;
      if (class_hit_cnt !== '0) begin
         n_err++;
         $display("FAIL bad_label_class4: got %0d want 0", class_hit_cnt);
      end
      $display("test_bad_label done");
   endtask

   task automatic test_reset_mid_run();
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, onehot(i % N), onehot(i % N));
      n_vec++;
      if (total_cnt !== W'(100)) begin
         n_err++;
         $display("FAIL pre_reset_total: got %0d want 100", total_cnt);
      end
      rst_n = 1'b0;
      cyc(1'b1, 1'b1, onehot(0), onehot(0));
      rst_n = 1'b1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || total_cnt !== '0 || correct_cnt !== '0) begin
         n_err++;
         $display("FAIL mid_reset: busy=%0b done=%0b tot=%0d cor=%0d want 0 0 0 0", busy, done, total_cnt, correct_cnt);
      end
      cyc(1'b0, 1'b1, onehot(0), onehot(0));
      n_vec++;
      if (busy !== 1'b0 || total_cnt !== '0) begin
         n_err++;
         $display("FAIL need_start: busy=%0b tot=%0d want 0 0", busy, total_cnt);
      end
      cyc(1'b1, 1'b1, onehot(3), onehot(3));
      n_vec++;
      if (busy !== 1'b1 || total_cnt !== '0 || correct_cnt !== '0) begin
         n_err++;
         $display("FAIL start_pv_ignored: busy=%0b tot=%0d cor=%0d want 1 0 0", busy, total_cnt, correct_cnt);
      end
      $display("test_reset_mid_run done");
   endtask

   task automatic test_restart();
      int guard;
      guard = 0;
      // Keep feeding samples, with stray start pulses, until the run completes.
      while (done !== 1'b1 && guard < 3 * NS) begin
         cyc((guard % 97) == 5, 1'b1, onehot(guard % N), onehot((guard % 3 == 0) ? (guard + 1) % N : guard % N));
         guard++;
      end
      n_vec++;
      if (done !== 1'b1 || total_cnt !== W'(NS) || correct_cnt !== W'(m_correct)) begin
         n_err++;
         $display("FAIL mid_start: done=%0b tot=%0d cor=%0d want 1 %0d %0d", done, total_cnt, correct_cnt, NS, m_correct);
      end
      cyc(1'b1, 1'b1, onehot(1), onehot(1));
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || total_cnt !== '0 || correct_cnt !== '0 || bad_label_cnt !== '0) begin
         n_err++;
         $display("FAIL restart: busy=%0b done=%0b tot=%0d cor=%0d bad=%0d want 1 0 0 0 0",
                  busy, done, total_cnt, correct_cnt, bad_label_cnt);
      end
      $display("test_restart done");
   endtask

   task automatic test_random();
      logic [N-1:0] p, l;
      logic         st, pv;
      int           k;
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      rst_n = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         k = $urandom_range(0, 9);
         l = onehot($urandom_range(0, N - 1));
         p = l;
         if (k >= 6 && k <= 7) p = onehot($urandom_range(0, N - 1));
         else if (k == 8) begin l = N'($urandom); p = l; end
         else if (k == 9) begin l = '0; p = N'($urandom); end
         st = ($urandom_range(0, 99) < 2) || (m_st == 0);
         pv = ($urandom_range(0, 9) < 8);
         rst_n = ($urandom_range(0, 1999) != 0);
         class_sel = 4'($urandom_range(0, 15));
         cyc(st, pv, p, l);
         n_vec++;
         if (busy !== (m_st == 1) || done !== (m_st == 2) || total_cnt !== W'(m_total) ||
             correct_cnt !== W'(m_correct) || bad_label_cnt !== W'(m_bad) ||
             class_hit_cnt !== W'(model_class(class_sel))) begin
            n_err++;
            $display("FAIL random c%0d: busy=%0b done=%0b tot=%0d cor=%0d bad=%0d cls[%0d]=%0d want %0b %0b %0d %0d %0d %0d",
                     c, busy, done, total_cnt, correct_cnt, bad_label_cnt, class_sel, class_hit_cnt,
                     m_st == 1, m_st == 2, m_total, m_correct, m_bad, model_class(class_sel));
         end
      end
      rst_n = 1'b1;
      $display("test_random done");
   endtask

   initial begin
      model_clear();
      test_reset();
      test_all_match();
      test_alternating();
      test_bad_label();
      test_reset_mid_run();
      test_restart();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
